// File: rtl/chan_rr_arbiter.sv
// ---- chan_rr_arbiter : shares one sync/notify output channel among N requesters, one buffered word at a time (rev 1.0)
`default_nettype none

module chan_rr_arbiter #(
   parameter int N      = 4,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N*DATA_W-1:0]   req_data,
   input  logic [N-1:0]          req_sync,
   output logic [N-1:0]          req_notify,
   input  logic                  prio_mode,
   output logic [DATA_W-1:0]     out_data,
   output logic [IDX_W-1:0]      out_src,
   output logic                  out_notify,
   input  logic                  out_sync,
   output logic [15:0]           xfer_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      SEND  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  last_grant, last_grant_nxt;
   logic [IDX_W-1:0]  grant_idx, grant_idx_nxt;
   logic [IDX_W-1:0]  rr_winner, fp_winner, winner;
   logic [N-1:0]      req_notify_nxt;
   logic              out_notify_nxt;
   logic [DATA_W-1:0] out_data_nxt;
   logic [IDX_W-1:0]  out_src_nxt;
   logic [15:0]       xfer_count_nxt;

   // Both scans run downward so the last hit is the nearest candidate.
   always_comb begin
      int               sum;
      logic [IDX_W-1:0] idx;
      rr_winner = '0;
      fp_winner = '0;
      sum       = 0;
      idx       = '0;
      for (int k = N; k >= 1; k--) begin
         sum = int'(last_grant) + k;
         if (sum >= N) sum = sum - N;
         idx = IDX_W'(sum);
         if (req_sync[idx]) rr_winner = idx;
      end
      for (int i = N - 1; i >= 0; i--) begin
         idx = IDX_W'(i);
         if (req_sync[idx]) fp_winner = idx;
      end
   end

   assign winner = prio_mode ? fp_winner : rr_winner;

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      grant_idx_nxt  = grant_idx;
      req_notify_nxt = '0;
      out_notify_nxt = 1'b0;
      out_data_nxt   = out_data;
      out_src_nxt    = out_src;
      xfer_count_nxt = xfer_count;
      case (state)
         IDLE: begin
            if (req_sync != '0) begin
               state_nxt              = GRANT;
               grant_idx_nxt          = winner;
               req_notify_nxt[winner] = 1'b1;
            end
         end
         GRANT: begin
            // A withdrawn request returns to IDLE without touching last_grant.
            if (req_sync[grant_idx]) begin
               state_nxt      = SEND;
               out_data_nxt   = req_data[grant_idx*DATA_W +: DATA_W];
               out_src_nxt    = grant_idx;
               out_notify_nxt = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         SEND: begin
            if (out_sync) begin
               state_nxt      = IDLE;
               last_grant_nxt = out_src;
               xfer_count_nxt = xfer_count + 16'd1;
            end else begin
               out_notify_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= IDX_W'(N - 1);
         grant_idx  <= '0;
         req_notify <= '0;
         out_notify <= 1'b0;
         out_data   <= '0;
         out_src    <= '0;
         xfer_count <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         grant_idx  <= grant_idx_nxt;
         req_notify <= req_notify_nxt;
         out_notify <= out_notify_nxt;
         out_data   <= out_data_nxt;
         out_src    <= out_src_nxt;
         xfer_count <= xfer_count_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_chan_rr_arbiter.sv
// ---- tb_chan_rr_arbiter : directed scoreboard bench for chan_rr_arbiter (N=4, DATA_W=32) (rev 1.0)
`default_nettype none

module tb_chan_rr_arbiter;
   localparam int N      = 4;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [N*DATA_W-1:0] req_data;
   logic [N-1:0]        req_sync;
   logic [N-1:0]        req_notify;
   logic                prio_mode;
   logic [DATA_W-1:0]   out_data;
   logic [IDX_W-1:0]    out_src;
   logic                out_notify;
   logic                out_sync;
   logic [15:0]         xfer_count;

   chan_rr_arbiter #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .req_data(req_data), .req_sync(req_sync),
      .req_notify(req_notify), .prio_mode(prio_mode), .out_data(out_data),
      .out_src(out_src), .out_notify(out_notify), .out_sync(out_sync),
      .xfer_count(xfer_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IDX_W-1:0]  src;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_err = 0;
   int   n_chk = 0;
   int   cyc   = 0;
   bit   last_xfer;
   bit   saw3;
   bit   seen_onotify;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int src, input int data);
      exp_t e;
      e.src  = IDX_W'(src);
      e.data = DATA_W'(data);
      sb.push_back(e);
   endtask

   task automatic setd(input int i, input int v);
      req_data[i*DATA_W +: DATA_W] = DATA_W'(v);
   endtask

   // Called at a negedge with inputs final: a transfer happens at the coming posedge iff notify&sync.
   task automatic tick();
      exp_t e;
      last_xfer = out_notify && out_sync;
      if (last_xfer) begin
         check("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_src", 32'(out_src), 32'(e.src));
            check("out_data", out_data, e.data);
         end
      end
      @(negedge clk);
      cyc++;
      check("onehot", 32'($onehot0(req_notify)), 1);
      check("excl", 32'((req_notify != '0) && out_notify), 0);
      if (req_notify[3]) saw3 = 1'b1;
      if (out_notify) seen_onotify = 1'b1;
   endtask

   task automatic drain(input int budget, input bit chk_period);
      int c    = 0;
      int prev = -1;
      while (sb.size() != 0 && c < budget) begin
         tick();
         c++;
         if (last_xfer && chk_period) begin
            if (prev >= 0) check("period", 32'(cyc - prev), 3);
            prev = cyc;
         end
      end
      check("drain", 32'(sb.size()), 0);
   endtask

   task automatic wait_onotify(input string tag);
      int c = 0;
      while (!out_notify && c < 12) begin
         tick();
         c++;
      end
      check(tag, 32'(out_notify), 1);
   endtask

   initial begin
      rst       = 1'b0;
      req_data  = '0;
      req_sync  = '0;
      prio_mode = 1'b0;
      out_sync  = 1'b0;
      saw3      = 1'b0;
      seen_onotify = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Idle after reset
      repeat (10) tick();
      check("rst_req_notify", 32'(req_notify), 0);
      check("rst_out_notify", 32'(out_notify), 0);
      check("rst_xfer_count", 32'(xfer_count), 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_src", 32'(out_src), 0);
      check("rst_no_offer", 32'(seen_onotify), 0);

      // Round-robin, all requesters active
      for (int i = 0; i < N; i++) setd(i, 10 + i);
      req_sync = 4'b1111;
      out_sync = 1'b1;
      push(0, 10); push(1, 11); push(2, 12); push(3, 13); push(0, 10);
      drain(40, 1'b1);
      req_sync = '0;
      tick();
      check("rr_xfer_count", 32'(xfer_count), 5);

      // Fixed priority with 1 and 3, then switch to round-robin mid-stream
      setd(1, 21); setd(3, 23);
      prio_mode = 1'b1;
      req_sync  = 4'b1010;
      saw3      = 1'b0;
      push(1, 21); push(1, 21); push(1, 21);
      begin
         int c = 0;
         while (sb.size() > 1 && c < 30) begin
            tick();
            c++;
         end
      end
      wait_onotify("prio_third_offer");
      prio_mode = 1'b0;
      check("prio_no_notify3", 32'(saw3), 0);
      push(3, 23); push(1, 21);
      drain(30, 1'b1);
      req_sync = '0;
      tick();
      check("prio_xfer_count", 32'(xfer_count), 10);

      // Backpressure on requester 3
      setd(3, 77);
      req_sync = 4'b1000;
      out_sync = 1'b0;
      push(3, 77);
      wait_onotify("bp_offer");
      req_sync = '0;
      repeat (7) begin
         tick();
         check("bp_out_notify", 32'(out_notify), 1);
         check("bp_out_data", out_data, 77);
         check("bp_req_notify", 32'(req_notify), 0);
      end
      check("bp_pending", 32'(sb.size()), 1);
      out_sync = 1'b1;
      tick();
      tick();
      check("bp_xfer_count", 32'(xfer_count), 11);
      check("bp_out_notify_low", 32'(out_notify), 0);
      check("bp_drained", 32'(sb.size()), 0);

      // Withdraw: requester 2 syncs for one cycle only
      setd(0, 50); setd(2, 52);
      req_sync = 4'b0100;
      tick();
      check("wd_grant2", 32'(req_notify), 32'h4);
      req_sync     = '0;
      seen_onotify = 1'b0;
      repeat (4) tick();
      check("wd_req_notify", 32'(req_notify), 0);
      check("wd_no_offer", 32'(seen_onotify), 0);
      check("wd_xfer_count", 32'(xfer_count), 11);
      req_sync = 4'b0101;
      push(0, 50); push(2, 52);
      drain(20, 1'b1);
      req_sync = '0;
      tick();
      check("wd_xfer_count2", 32'(xfer_count), 13);

      // Reset while a word is held in SEND
      setd(0, 1337);
      req_sync = 4'b0001;
      out_sync = 1'b0;
      wait_onotify("rs_offer");
      req_sync = '0;
      check("rs_buffered", out_data, 1337);
      #2 rst = 1'b0;
      #1;
      check("rs_async_out_notify", 32'(out_notify), 0);
      check("rs_xfer_count", 32'(xfer_count), 0);
      check("rs_out_data", out_data, 0);
      @(negedge clk);
      rst          = 1'b1;
      out_sync     = 1'b1;
      seen_onotify = 1'b0;
      repeat (6) tick();
      check("rs_no_delivery", 32'(seen_onotify), 0);
      check("rs_xfer_after", 32'(xfer_count), 0);
      check("rs_data_after", out_data, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "bench timeout");
   end

endmodule

`default_nettype wire
